micro_uart_arbiter: RTL

//  Two-master OCP arbiter that shares one micro UART slave port (character register at offset 0x000).

---
 rtl/micro_uart_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/micro_uart_arbiter.sv
// rtl/micro_uart_arbiter.sv - two-master round-robin OCP arbiter in front of the micro UART slave port
// Define MUART_ARB_TIMEOUT_EN to build the read-response watchdog.
module micro_uart_arbiter #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int BEN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [ADDR_WIDTH-1:0] i_M0Addr,
  input  logic [2:0]            i_M0Cmd,
  input  logic [DATA_WIDTH-1:0] i_M0Data,
  input  logic [BEN_WIDTH-1:0]  i_M0ByteEn,
  output logic                  o_M0SCmdAccept,
  output logic [DATA_WIDTH-1:0] o_M0SData,
  output logic [1:0]            o_M0SResp,
  input  logic [ADDR_WIDTH-1:0] i_M1Addr,
  input  logic [2:0]            i_M1Cmd,
  input  logic [DATA_WIDTH-1:0] i_M1Data,
  input  logic [BEN_WIDTH-1:0]  i_M1ByteEn,
  output logic                  o_M1SCmdAccept,
  output logic [DATA_WIDTH-1:0] o_M1SData,
  output logic [1:0]            o_M1SResp,
  output logic [ADDR_WIDTH-1:0] o_MAddr,
  output logic [2:0]            o_MCmd,
  output logic [DATA_WIDTH-1:0] o_MData,
  output logic [BEN_WIDTH-1:0]  o_MByteEn,
  input  logic                  i_SCmdAccept,
  input  logic [DATA_WIDTH-1:0] i_SData,
  input  logic [1:0]            i_SResp
);

  localparam logic [2:0] OCP_CMD_IDLE  = 3'b000;
  localparam logic [2:0] OCP_CMD_RD    = 3'b010;
  localparam logic [1:0] OCP_RESP_NULL = 2'b00;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_RESP} state_e;

  state_e                state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  last_q, last_d;
  logic                  req0, req1;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [2:0]            sel_cmd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [BEN_WIDTH-1:0]  sel_ben;
  logic                  acc;
  logic [1:0]            rsp;
  logic [DATA_WIDTH-1:0] rsp_data;

  assign req0     = (i_M0Cmd != OCP_CMD_IDLE);
  assign req1     = (i_M1Cmd != OCP_CMD_IDLE);
  assign sel_addr = gnt_q ? i_M1Addr   : i_M0Addr;
  assign sel_cmd  = gnt_q ? i_M1Cmd    : i_M0Cmd;
  assign sel_data = gnt_q ? i_M1Data   : i_M0Data;
  assign sel_ben  = gnt_q ? i_M1ByteEn : i_M0ByteEn;

`ifdef MUART_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] OCP_RESP_ERR = 2'b11;

  logic [7:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Pointer resets to M1 so that M0 wins the first tie.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
`ifdef MUART_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    o_MAddr   = '0;
    o_MCmd    = OCP_CMD_IDLE;
    o_MData   = '0;
    o_MByteEn = '0;
    acc       = 1'b0;
    rsp       = OCP_RESP_NULL;
    rsp_data  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          gnt_d   = (req0 && req1) ? ~last_q : req1;
          last_d  = gnt_d;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        o_MAddr   = sel_addr;
        o_MCmd    = sel_cmd;
        o_MData   = sel_data;
        o_MByteEn = sel_ben;
        acc       = i_SCmdAccept;
        // Writes are posted; only reads wait for a response.
        if (i_SCmdAccept) begin
          if (sel_cmd == OCP_CMD_RD) begin
            state_d = S_RESP;
`ifdef MUART_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_RESP: begin
        if (i_SResp != OCP_RESP_NULL) begin
          rsp      = i_SResp;
          rsp_data = i_SData;
          state_d  = S_IDLE;
        end
`ifdef MUART_ARB_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          rsp     = OCP_RESP_ERR;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_M0SCmdAccept = acc & ~gnt_q;
  assign o_M1SCmdAccept = acc & gnt_q;
  assign o_M0SResp      = gnt_q ? OCP_RESP_NULL : rsp;
  assign o_M1SResp      = gnt_q ? rsp : OCP_RESP_NULL;
  assign o_M0SData      = gnt_q ? '0 : rsp_data;
  assign o_M1SData      = gnt_q ? rsp_data : '0;

endmodule
